flash_read_responder: RTL and testbench
=======================================

Name: flash_read_responder

Overview:
- Avalon-MM read-only slave that models the responding end of the flash read channel, so the audio fetch master can be exercised in simulation and on-board without real flash.
- It accepts reads through a waitrequest handshake and returns data from an internal word array with a fixed readdatavalid latency.
- It tracks outstanding reads and throttles acceptance at a configurable limit.
- The array is preloaded through a side load port by the bench or the board init logic.

Parameters:
- ADDR_W, 23: width of s_address (word address).
- DATA_W, 32: width of s_readdata and load_data.
- MEM_AW, 8: internal array address bits; the array holds 2**MEM_AW words.
- WAIT_CYCLES, 2: extra waitrequest-high cycles before a grant; legal range 0..15.
- READ_LATENCY, 4: cycles from the accept cycle to the readdatavalid cycle; legal range 1..15.
- MAX_PENDING, 2: maximum accepted reads not yet returned; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- s_address  in  ADDR_W  read word address.
- s_read  in  1  read request.
- s_waitrequest  out  1  stall; a read is accepted only in a cycle with s_read=1 and s_waitrequest=0.
- s_readdata  out  DATA_W  returned data.
- s_readdatavalid  out  1  one-cycle strobe qualifying s_readdata.
- load_en  in  1  array write strobe.
- load_addr  in  MEM_AW  array write address.
- load_data  in  DATA_W  array write data.
- pending_count  out  4  reads accepted but not yet returned.

Behaviour:
- Reset, synchronous and active-high:
  - s_waitrequest=1, s_readdatavalid=0, s_readdata=0, pending_count=0, FSM=IDLE.
  - The return pipeline is cleared, so in-flight reads are dropped and never return.
  - Array contents are not reset.
- All outputs are registered.
- FSM states:
  - IDLE: s_waitrequest=1.
    - If s_read=1 and pending_count<MAX_PENDING: go to GRANT when WAIT_CYCLES=0, else go to STALL with wait_cnt=WAIT_CYCLES-1.
    - Otherwise stay in IDLE.
  - STALL: s_waitrequest=1.
    - If s_read=0, return to IDLE (request withdrawn, nothing accepted).
    - Else if wait_cnt=0, go to GRANT.
    - Else decrement wait_cnt.
  - GRANT: s_waitrequest=0 for exactly this one cycle, then IDLE.
    - If s_read=1, the read is accepted this cycle.
    - If s_read=0, nothing is accepted.
- Timing: s_read first sampled high in IDLE at cycle t gives s_waitrequest=0 at cycle t+WAIT_CYCLES+1. Back-to-back accepts are therefore at least WAIT_CYCLES+2 cycles apart.
- Address sampling on accept:
  - s_address is sampled in the accept cycle.
  - If s_address[ADDR_W-1:MEM_AW] is nonzero, data = 0; otherwise data = array[s_address[MEM_AW-1:0]] as seen in that cycle.
  - Data and a valid bit enter a READ_LATENCY-deep shift pipeline.
- Return: for an accept at cycle a, s_readdatavalid=1 and s_readdata=data at cycle a+READ_LATENCY.
  - s_readdata holds its last value while s_readdatavalid=0.
  - Returns are in order and never collide, because accept spacing is at least 2.
- pending_count:
  - +1 on accept, -1 on a readdatavalid cycle; both in the same cycle leaves it unchanged.
  - It never exceeds MAX_PENDING.
  - The throttle compares against the registered value only.
- Load port:
  - load_en writes the array at the clock edge.
  - A load and an accept to the same word in the same cycle: the read returns the old word.
  - Loads are legal at any time, including during reset.
- reset asserted in any state overrides everything at the next edge.

Test Plan:
- Preload array[0x05]=0xCAFE0005. Hold s_read=1, s_address=0x05 from cycle 10.
  - s_waitrequest=0 only at cycle 13 (accept).
  - s_readdatavalid=1 with s_readdata=0xCAFE0005 only at cycle 17.
  - pending_count is 1 for cycles 14-17 and 0 from cycle 18.
- WAIT_CYCLES=0, READ_LATENCY=4, MAX_PENDING=2, s_read held high at addresses 0,1,2.
  - Accepts at 11 and 13; third accept stalled until pending drops.
  - pending_count peaks at 2; returns at 15 and 17 carry array[0] and array[1].
- Drop s_read in STALL (cycle 12) -> no accept, no readdatavalid, pending_count stays 0, FSM back to IDLE.
- s_address=0x000100 with MEM_AW=8 -> read accepted, returned s_readdata=0x00000000 at latency 4.
- Same-cycle load_en (array[0x07]: 0x11111111 -> 0x22222222) and accept of 0x07 -> returns 0x11111111. A later read of 0x07 returns 0x22222222.
- Assert reset for 1 cycle, 2 cycles after an accept:
  - No readdatavalid follows; pending_count=0 and s_waitrequest=1 after the reset edge.
  - The next read is granted normally WAIT_CYCLES+1 cycles after s_read is sampled.

Source files
------------

// File: rtl/flash_read_responder_if.sv
// flash_read_responder_if: Avalon-MM read channel between the fetch master
// and the flash read responder.
interface flash_read_responder_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;

    modport master (
        output s_address,
        output s_read,
        input  s_waitrequest,
        input  s_readdata,
        input  s_readdatavalid
    );

    modport slave (
        input  s_address,
        input  s_read,
        output s_waitrequest,
        output s_readdata,
        output s_readdatavalid
    );
endinterface

// File: rtl/flash_read_responder.sv
// flash_read_responder: read-only Avalon-MM slave standing in for flash,
// with programmable stall, fixed return latency and an outstanding limit.
module flash_read_responder #(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 32,
    parameter int MEM_AW       = 8,
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 4,
    parameter int MAX_PENDING  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    flash_read_responder_if.slave s,
    input  logic                  load_en,
    input  logic [MEM_AW-1:0]     load_addr,
    input  logic [DATA_W-1:0]     load_data,
    output logic [3:0]            pending_count
);

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        GRANT
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] mem [2**MEM_AW];
    logic              accept;
    logic [DATA_W-1:0] rd_word;
    logic              tail_vld;
    logic [DATA_W-1:0] tail_data;

    // Only the granted cycle has waitrequest low, so this is the accept.
    assign accept  = s.s_read & ~s.s_waitrequest;
    // Addresses beyond the array read as zero.
    assign rd_word = (|s.s_address[ADDR_W-1:MEM_AW]) ? '0
                   : mem[s.s_address[MEM_AW-1:0]];

    // Side load port; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
    end

    // Request handshake: optional stall, then a single-cycle grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            s.s_waitrequest <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s.s_read && pending_count < 4'(MAX_PENDING)) begin
                        if (WAIT_CYCLES == 0) begin
                            state           <= GRANT;
                            s.s_waitrequest <= 1'b0;
                        end else begin
                            state    <= STALL;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    if (!s.s_read) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state           <= GRANT;
                        s.s_waitrequest <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                GRANT: begin
                    state           <= IDLE;
                    s.s_waitrequest <= 1'b1;
                end
                default: begin
                    state           <= IDLE;
                    s.s_waitrequest <= 1'b1;
                end
            endcase
        end
    end

    // Return pipeline; the output register is the final latency stage.
    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign tail_vld  = accept;
            assign tail_data = rd_word;
        end else begin : g_pipe
            localparam int D = READ_LATENCY - 1;
            logic [D-1:0]      vld;
            logic [DATA_W-1:0] dat [D];

            // Valid bits are cleared by reset so in-flight reads vanish.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld <= '0;
                end else begin
                    vld[0] <= accept;
                    for (int i = 1; i < D; i++)
                        vld[i] <= vld[i-1];
                end
            end

            // Data rides alongside its valid bit.
            always_ff @(posedge clk) begin
                dat[0] <= rd_word;
                for (int i = 1; i < D; i++)
                    dat[i] <= dat[i-1];
            end

            assign tail_vld  = vld[D-1];
            assign tail_data = dat[D-1];
        end
    endgenerate

    // Registered return; readdata holds between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            s.s_readdatavalid <= 1'b0;
            s.s_readdata      <= '0;
        end else begin
            s.s_readdatavalid <= tail_vld;
            if (tail_vld)
                s.s_readdata <= tail_data;
        end
    end

    // Outstanding count: up on accept, down on each return strobe.
    always_ff @(posedge clk) begin
        if (reset)
            pending_count <= '0;
        else
            pending_count <= pending_count + {3'b0, accept}
                           - {3'b0, s.s_readdatavalid};
    end

endmodule

// File: tb/tb_flash_read_responder.sv
// tb_flash_read_responder: directed scenarios plus random traffic checked
// against a transaction-level model of grants, returns and loads.
module tb_flash_read_responder;

    localparam int AW  = 23;
    localparam int DW  = 32;
    localparam int MAW = 8;
    localparam int WC  = 1;
    localparam int RL  = 4;
    localparam int MP  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           load_en;
    logic [MAW-1:0] load_addr;
    logic [DW-1:0]  load_data;
    logic [3:0]     pending_count;

    always #5 clk = ~clk;

    flash_read_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    flash_read_responder #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MEM_AW      (MAW),
        .WAIT_CYCLES (WC),
        .READ_LATENCY(RL),
        .MAX_PENDING (MP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s            (bus.slave),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .pending_count(pending_count)
    );

    typedef struct {
        longint        due;
        logic [DW-1:0] d;
    } ret_t;

    logic [DW-1:0] mem_m [2**MAW];
    ret_t          rq[$];
    longint        grant_at = -1;
    longint        cyc = 0;
    logic [DW-1:0] rd_hold = '0;
    bit            model_on = 1'b0;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model,
    // advance the model with this cycle's inputs, then move to next cycle.
    task automatic step(input bit rd, input logic [AW-1:0] a,
                        input bit le, input logic [MAW-1:0] la,
                        input logic [DW-1:0] ld, input bit rst);
        bit            acc;
        bit            vexp;
        logic [DW-1:0] dat;
        reset         = rst;
        bus.s_read    = rd;
        bus.s_address = a;
        load_en       = le;
        load_addr     = la;
        load_data     = ld;
        vexp = (rq.size() > 0) && (rq[0].due == cyc);
        if (vexp)
            rd_hold = rq[0].d;
        if (model_on) begin
            chk("waitrequest", bus.s_waitrequest, (grant_at == cyc) ? 1'b0 : 1'b1);
            chk("readdatavalid", bus.s_readdatavalid, vexp);
            chk("readdata", bus.s_readdata, rd_hold);
            chk("pending_count", pending_count, rq.size());
        end
        acc = 1'b0;
        if (grant_at == cyc) begin
            acc      = rd;
            grant_at = -1;
        end else if (grant_at > cyc) begin
            if (!rd)
                grant_at = -1;
        end else if (rd && rq.size() < MP) begin
            grant_at = cyc + WC + 1;
        end
        if (vexp)
            void'(rq.pop_front());
        if (acc) begin
            dat = (a[AW-1:MAW] != 0) ? '0 : mem_m[a[MAW-1:0]];
            rq.push_back('{cyc + RL, dat});
        end
        if (le)
            mem_m[la] = ld;
        if (rst) begin
            rq.delete();
            grant_at = -1;
            rd_hold  = '0;
            model_on = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rdq(input logic [AW-1:0] a, input int n);
        repeat (n) step(1'b1, a, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic load(input logic [MAW-1:0] la, input logic [DW-1:0] ld);
        step(1'b0, '0, 1'b1, la, ld, 1'b0);
    endtask

    initial begin
        int          mask;
        int          peak;
        logic [AW-1:0] ra;
        reset         = 1'b1;
        bus.s_read    = 1'b0;
        bus.s_address = '0;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        @(posedge clk);
        #1;

        // Fill the array while held in reset.
        for (int i = 0; i < 2**MAW; i++)
            step(1'b0, '0, 1'b1, MAW'(i), DW'($urandom), 1'b1);
        chk("rst_waitrequest", bus.s_waitrequest, 1);
        chk("rst_valid", bus.s_readdatavalid, 0);
        chk("rst_readdata", bus.s_readdata, 0);
        chk("rst_pending", pending_count, 0);

        // Basic read with one stall cycle.
        load(8'h05, 32'hCAFE0005);
        idle(2);
        rdq(23'h5, 1);
        chk("s1_stall_wr", bus.s_waitrequest, 1);
        rdq(23'h5, 1);
        chk("s1_grant_wr", bus.s_waitrequest, 0);
        rdq(23'h5, 1);
        chk("s1_pend_one", pending_count, 1);
        idle(3);
        chk("s1_valid", bus.s_readdatavalid, 1);
        chk("s1_data", bus.s_readdata, 32'hCAFE0005);
        idle(1);
        chk("s1_pend_zero", pending_count, 0);
        chk("s1_hold", bus.s_readdata, 32'hCAFE0005);

        // Request withdrawn during the stall.
        rdq(23'h5, 1);
        step(1'b0, 23'h5, 1'b0, '0, '0, 1'b0);
        chk("s2_wr_a", bus.s_waitrequest, 1);
        idle(1);
        chk("s2_wr_b", bus.s_waitrequest, 1);
        idle(6);
        chk("s2_pend", pending_count, 0);

        // Out-of-range address returns zero.
        load(8'h00, 32'hA5A5A5A5);
        idle(1);
        rdq(23'h000100, 3);
        idle(3);
        chk("s3_valid", bus.s_readdatavalid, 1);
        chk("s3_zero", bus.s_readdata, 0);
        idle(2);

        // Load and accept of the same word in one cycle.
        load(8'h07, 32'h11111111);
        idle(1);
        rdq(23'h7, 2);
        step(1'b1, 23'h7, 1'b1, 8'h07, 32'h22222222, 1'b0);
        idle(3);
        chk("s4_old", bus.s_readdata, 32'h11111111);
        idle(1);
        rdq(23'h7, 3);
        idle(3);
        chk("s4_new", bus.s_readdata, 32'h22222222);
        idle(2);

        // Continuous requests hit the outstanding limit.
        mask = 0;
        peak = 0;
        for (int i = 0; i < 12; i++) begin
            if (!bus.s_waitrequest)
                mask |= (1 << i);
            if (int'(pending_count) > peak)
                peak = int'(pending_count);
            rdq(AW'(i), 1);
        end
        chk("s5_grant_mask", mask, 32'h224);
        chk("s5_peak", peak, 2);
        idle(8);

        // Reset two cycles after an accept drops the read.
        rdq(23'h5, 3);
        idle(1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        chk("s6_pend", pending_count, 0);
        chk("s6_wr", bus.s_waitrequest, 1);
        for (int i = 0; i < 6; i++) begin
            chk("s6_no_return", bus.s_readdatavalid, 0);
            idle(1);
        end
        rdq(23'h5, 2);
        chk("s6_regrant", bus.s_waitrequest, 0);
        rdq(23'h5, 1);
        idle(6);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            ra = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0)
                ra = AW'($urandom);
            step($urandom_range(0, 3) != 0, ra,
                 $urandom_range(0, 3) == 0, MAW'($urandom), DW'($urandom),
                 $urandom_range(0, 199) == 0);
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
